fifo_skew_scheduler: RTL and testbench

//  Sequences ROWS instances of fifo_mem that feed the west edge of the systolic array.

---
 rtl/fifo_skew_scheduler_pkg.sv | 14 +
 rtl/fifo_skew_scheduler_if.sv | 40 ++++
 rtl/fifo_skew_scheduler_read_gen.sv | 40 ++++
 rtl/fifo_skew_scheduler.sv | 126 ++++++++++++
 tb/tb_fifo_skew_scheduler.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_skew_scheduler_pkg.sv
// fifo_skew_scheduler_pkg: shared state type, default sizes and the skew read window
package fifo_skew_scheduler_pkg;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int ROWS_DEF       = 4;
    localparam int LENGTH_DEF     = 16;
    localparam int READ_LAT_DEF   = 1;

    typedef enum logic [2:0] {IDLE, LOAD, DRAIN, FLUSH, DONE, ERR} sched_state_t;

    // Row i reads during the k cycles that start at t == i, producing the diagonal skew
    function automatic logic skew_window(input int t, input int i, input int k);
        return (t >= i) && (t < i + k);
    endfunction
endpackage

// File: rtl/fifo_skew_scheduler_if.sv
// fifo_skew_scheduler_if: control, input stream, row FIFO and status bundle of the scheduler
interface fifo_skew_scheduler_if
    import fifo_skew_scheduler_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ROWS       = ROWS_DEF,
    parameter int LENGTH     = LENGTH_DEF
) ();
    localparam int KW = $clog2(LENGTH + 1);

    logic                  start;
    logic                  abort;
    logic [KW-1:0]         k_len;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic [ROWS-1:0]       fifo_write;
    logic [DATA_WIDTH-1:0] fifo_wdata;
    logic [ROWS-1:0]       fifo_read;
    logic [ROWS-1:0]       fifo_full;
    logic [ROWS-1:0]       fifo_empty;
    logic [ROWS-1:0]       fifo_overflow;
    logic [ROWS-1:0]       fifo_underflow;
    logic [ROWS-1:0]       row_valid;
    logic                  busy;
    logic                  done;
    logic                  error;

    modport master (
        output start, abort, k_len, in_valid, in_data,
               fifo_full, fifo_empty, fifo_overflow, fifo_underflow,
        input  in_ready, fifo_write, fifo_wdata, fifo_read, row_valid, busy, done, error
    );

    modport slave (
        input  start, abort, k_len, in_valid, in_data,
               fifo_full, fifo_empty, fifo_overflow, fifo_underflow,
        output in_ready, fifo_write, fifo_wdata, fifo_read, row_valid, busy, done, error
    );
endinterface

// File: rtl/fifo_skew_scheduler_read_gen.sv
// skew_read_gen: per-row skewed read strobes and the row_valid delay line
module skew_read_gen
    import fifo_skew_scheduler_pkg::*;
#(
    parameter int ROWS     = ROWS_DEF,
    parameter int READ_LAT = READ_LAT_DEF,
    parameter int TW       = 5,
    parameter int KW       = 5
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            en_i,
    input  logic            clr_i,
    input  logic [TW-1:0]   t_i,
    input  logic [KW-1:0]   k_i,
    output logic [ROWS-1:0] rd_o,
    output logic [ROWS-1:0] row_valid_o
);
    logic [ROWS-1:0] pipe_q [READ_LAT];

    // One window comparator per row, live only while draining
    always_comb begin
        rd_o = '0;
        for (int i = 0; i < ROWS; i++) rd_o[i] = en_i && skew_window(int'(t_i), i, int'(k_i));
    end

    // Delay the read strobes by the FIFO read latency so they line up with fifo data_out
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < READ_LAT; s++) pipe_q[s] <= '0;
        end else if (clr_i) begin
            for (int s = 0; s < READ_LAT; s++) pipe_q[s] <= '0;
        end else begin
            pipe_q[0] <= rd_o;
            for (int s = 1; s < READ_LAT; s++) pipe_q[s] <= pipe_q[s-1];
        end
    end

    assign row_valid_o = pipe_q[READ_LAT-1];
endmodule

// File: rtl/fifo_skew_scheduler.sv
// fifo_skew_scheduler: loads a row-major tile into row FIFOs, then drains them with diagonal skew
module fifo_skew_scheduler
    import fifo_skew_scheduler_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ROWS       = ROWS_DEF,
    parameter int LENGTH     = LENGTH_DEF,
    parameter int READ_LAT   = READ_LAT_DEF
) (
    input logic                  clk,
    input logic                  reset_n,
    fifo_skew_scheduler_if.slave bus
);
    localparam int KW = $clog2(LENGTH + 1);
    localparam int TW = $clog2(LENGTH + ROWS + READ_LAT);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(LENGTH);

    sched_state_t  state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [TW-1:0] t_q, t_d;
    logic          accept, fault, col_last, row_last, t_last, flush_last;

    assign fault      = |(bus.fifo_overflow | bus.fifo_underflow);
    assign col_last   = KW'(col_q) + KW'(1) == k_q;
    assign row_last   = row_q == RW'(ROWS - 1);
    assign t_last     = t_q == TW'(k_q) + TW'(ROWS - 2);
    assign flush_last = t_q == TW'(READ_LAT - 1);

    assign bus.in_ready   = state_q == LOAD && !bus.abort && !bus.fifo_full[row_q];
    assign accept         = bus.in_ready && bus.in_valid;
    assign bus.fifo_wdata = accept ? bus.in_data : '0;
    assign bus.busy       = state_q != IDLE;
    assign bus.done       = state_q == DONE;
    assign bus.error      = state_q == ERR;

    // Steer each accepted element into the FIFO of the row being loaded
    always_comb begin
        bus.fifo_write = '0;
        bus.fifo_write[row_q] = accept;
    end

    // Next state and counters; abort beats everything, a FIFO fault beats progress
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        row_d   = row_q;
        col_d   = col_q;
        t_d     = t_q;
        if (bus.abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (bus.start) begin
                    state_d = bus.k_len == '0 ? DONE : (bus.k_len > KW'(LENGTH) ? ERR : LOAD);
                    k_d     = bus.k_len;
                    row_d   = '0;
                    col_d   = '0;
                end
                LOAD: if (fault) begin
                    state_d = ERR;
                end else if (accept) begin
                    col_d = col_last ? '0 : col_q + 1'b1;
                    row_d = col_last && !row_last ? row_q + 1'b1 : row_q;
                    if (col_last && row_last) begin
                        state_d = DRAIN;
                        t_d     = '0;
                    end
                end
                DRAIN: if (fault) begin
                    state_d = ERR;
                end else if (t_last) begin
                    state_d = FLUSH;
                    t_d     = '0;
                end else begin
                    t_d = t_q + 1'b1;
                end
                FLUSH: if (fault) begin
                    state_d = ERR;
                end else if (flush_last) begin
                    state_d = DONE;
                end else begin
                    t_d = t_q + 1'b1;
                end
                DONE:    state_d = IDLE;
                ERR:     state_d = ERR;
                default: state_d = IDLE;
            endcase
        end
    end

    // State and counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            row_q   <= '0;
            col_q   <= '0;
            t_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            row_q   <= row_d;
            col_q   <= col_d;
            t_q     <= t_d;
        end
    end

    skew_read_gen #(
        .ROWS    (ROWS),
        .READ_LAT(READ_LAT),
        .TW      (TW),
        .KW      (KW)
    ) u_read_gen (
        .clk        (clk),
        .reset_n    (reset_n),
        .en_i       (state_q == DRAIN && !bus.abort),
        .clr_i      (bus.abort),
        .t_i        (t_q),
        .k_i        (k_q),
        .rd_o       (bus.fifo_read),
        .row_valid_o(bus.row_valid)
    );
endmodule

// File: tb/tb_fifo_skew_scheduler.sv
// tb_fifo_skew_scheduler: directed tiles checked every cycle against a timeline model of the scheduler
module tb_fifo_skew_scheduler;
    localparam int R  = 4;
    localparam int L  = 16;
    localparam int RL = 1;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    fifo_skew_scheduler_if #(.DATA_WIDTH(DW), .ROWS(R), .LENGTH(L)) bus ();

    fifo_skew_scheduler #(.DATA_WIDTH(DW), .ROWS(R), .LENGTH(L), .READ_LAT(RL)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] src [64];
    logic [R-1:0]  rd_log [$];
    logic [R-1:0]  wr_log [$];
    logic [DW-1:0] wd_log [$];
    int rd_first, rv_first, rv_last, done_cyc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic clr_logs();
        rd_log.delete();
        wr_log.delete();
        wd_log.delete();
        rd_first = -1;
        rv_first = -1;
        rv_last  = -1;
        done_cyc = -1;
    endtask

    // Model: phase 0 idle, 1 loading (m_n accepted so far), 2 timed run from drain cycle m_d0, 3 error
    initial begin
        int m_ph, m_k, m_n, m_d0, t, mr;
        logic [R-1:0] m_rd_prev, e_wr, e_rd;
        logic [DW-1:0] e_wd;
        logic e_ready, e_acc, e_done, fault;
        m_ph = 0; m_k = 0; m_n = 0; m_d0 = 0; m_rd_prev = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                m_ph = 0;
                m_rd_prev = '0;
                chk("reset_outputs", {bus.in_ready, bus.busy, bus.done, bus.error, bus.fifo_write,
                                      bus.fifo_read, bus.row_valid, bus.fifo_wdata}, 0);
            end else begin
                t  = cyc - m_d0;
                mr = m_k > 0 ? m_n / m_k : 0;
                e_ready = m_ph == 1 && !bus.abort && !bus.fifo_full[mr];
                e_acc   = e_ready && bus.in_valid;
                e_wr = '0;
                if (e_acc) e_wr[mr] = 1'b1;
                e_wd = e_acc ? src[m_n] : '0;
                e_rd = '0;
                if (m_ph == 2 && !bus.abort)
                    for (int i = 0; i < R; i++) e_rd[i] = t >= i && t < i + m_k;
                e_done = m_ph == 2 && t == m_k + R - 1 + RL;
                chk("in_ready", bus.in_ready, e_ready);
                chk("fifo_write", bus.fifo_write, e_wr);
                chk("fifo_wdata", bus.fifo_wdata, e_wd);
                chk("fifo_read", bus.fifo_read, e_rd);
                chk("row_valid", bus.row_valid, m_rd_prev);
                chk("busy", bus.busy, m_ph != 0);
                chk("done", bus.done, e_done);
                chk("error", bus.error, m_ph == 3);
                if (bus.fifo_read != 0) begin
                    if (rd_log.size() == 0) rd_first = cyc;
                    rd_log.push_back(bus.fifo_read);
                end
                if (bus.fifo_write != 0) begin
                    wr_log.push_back(bus.fifo_write);
                    wd_log.push_back(bus.fifo_wdata);
                end
                if (bus.row_valid != 0) begin
                    if (rv_first < 0) rv_first = cyc;
                    rv_last = cyc;
                end
                if (bus.done) done_cyc = cyc;
            end
            @(posedge clk);
            if (reset_n) begin
                fault = |(bus.fifo_overflow | bus.fifo_underflow);
                m_rd_prev = bus.abort ? '0 : e_rd;
                if (bus.abort) begin
                    m_ph = 0;
                end else if (m_ph == 0) begin
                    if (bus.start) begin
                        if (bus.k_len == 0) begin
                            m_ph = 2; m_k = 0; m_d0 = cyc + 1 - (R - 1 + RL);
                        end else if (bus.k_len > L) begin
                            m_ph = 3;
                        end else begin
                            m_ph = 1; m_k = bus.k_len; m_n = 0;
                        end
                    end
                end else if (m_ph == 1) begin
                    if (fault) m_ph = 3;
                    else if (e_acc) begin
                        m_n++;
                        if (m_n == R * m_k) begin
                            m_ph = 2; m_d0 = cyc + 1;
                        end
                    end
                end else if (m_ph == 2) begin
                    if (e_done) m_ph = 0;
                    else if (fault) m_ph = 3;
                end
            end
            cyc++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input int k);
        bus.start = 1'b1;
        bus.k_len = 5'(k);
        step();
        bus.start = 1'b0;
    endtask

    // Stream src[0..n-1]; optionally hold fifo_full[1] for stall_len cycles when element stall_at is presented
    task automatic feed(input int n, input int stall_at, input int stall_len);
        int idx = 0, guard = 0, st = 0;
        logic acc;
        bus.in_valid = 1'b1;
        while (idx < n && guard < 400) begin
            bus.in_data   = src[idx];
            bus.fifo_full = (idx == stall_at && st < stall_len) ? 4'b0010 : 4'b0000;
            @(negedge clk);
            acc = bus.in_ready;
            step();
            if (bus.fifo_full != 0) st++;
            if (acc) idx++;
            guard++;
        end
        bus.in_valid  = 1'b0;
        bus.fifo_full = '0;
        chk("feed_count", idx, n);
    endtask

    task automatic wait_done(input string nm, input int lim);
        int c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!bus.done && c < lim);
        chk(nm, bus.done, 1);
        step();
    endtask

    logic [R-1:0] exp_rd1 [6] = '{4'h1, 4'h3, 4'h7, 4'hE, 4'hC, 4'h8};
    logic [R-1:0] exp_wr1 [12] = '{4'h1, 4'h1, 4'h1, 4'h2, 4'h2, 4'h2, 4'h4, 4'h4, 4'h4, 4'h8, 4'h8, 4'h8};
    logic [R-1:0] exp_rd2 [5] = '{4'h1, 4'h3, 4'h6, 4'hC, 4'h8};
    logic [R-1:0] exp_rd3 [4] = '{4'h1, 4'h2, 4'h4, 4'h8};

    initial begin
        bus.start = 0; bus.abort = 0; bus.k_len = 0; bus.in_valid = 0; bus.in_data = 0;
        bus.fifo_full = 0; bus.fifo_empty = 0; bus.fifo_overflow = 0; bus.fifo_underflow = 0;
        clr_logs();
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        step();

        // 1: k=3, twelve elements 1..12 streamed without gaps
        for (int i = 0; i < 64; i++) src[i] = DW'(i + 1);
        clr_logs();
        go(3);
        feed(12, -1, 0);
        wait_done("t1_done_seen", 30);
        chk("t1_nwr", wr_log.size(), 12);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("t1_wr%0d", i), i < wr_log.size() ? 32'(wr_log[i]) : 32'hdead, exp_wr1[i]);
            chk($sformatf("t1_wd%0d", i), i < wd_log.size() ? 32'(wd_log[i]) : 32'hdead, i + 1);
        end
        chk("t1_nrd", rd_log.size(), 6);
        for (int i = 0; i < 6; i++)
            chk($sformatf("t1_rd%0d", i), i < rd_log.size() ? 32'(rd_log[i]) : 32'hdead, exp_rd1[i]);
        chk("t1_rv_latency", rv_first - rd_first, RL);
        chk("t1_done_after_rv", done_cyc - rv_last, 1);

        // 2: empty tile goes straight to done; oversized tile errors
        clr_logs();
        go(0);
        @(negedge clk);
        chk("t2_k0_done", bus.done, 1);
        @(negedge clk);
        chk("t2_k0_pulse", {bus.busy, bus.done}, 0);
        chk("t2_k0_nostrobe", wr_log.size() + rd_log.size(), 0);
        step();
        go(17);
        @(negedge clk);
        chk("t2_k17_err", {bus.error, bus.busy}, 2'b11);
        step();
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        @(negedge clk);
        chk("t2_abort_clear", {bus.error, bus.busy}, 0);
        step();

        // 3: row 1 FIFO full for three cycles mid-row; order must survive the stall
        for (int i = 0; i < 64; i++) src[i] = DW'(8'hA0 + i);
        clr_logs();
        go(3);
        feed(12, 4, 3);
        wait_done("t3_done_seen", 30);
        chk("t3_nwr", wd_log.size(), 12);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("t3_wd%0d", i), i < wd_log.size() ? 32'(wd_log[i]) : 32'hdead, 8'hA0 + i);
            chk($sformatf("t3_wr%0d", i), i < wr_log.size() ? 32'(wr_log[i]) : 32'hdead, exp_wr1[i]);
        end

        // 4: underflow on row 2 mid-drain, then abort
        go(3);
        feed(12, -1, 0);
        step();
        step();
        bus.fifo_underflow = 4'b0100;
        step();
        bus.fifo_underflow = '0;
        @(negedge clk);
        chk("t4_err", {bus.error, bus.busy}, 2'b11);
        chk("t4_strobes", {bus.fifo_read, bus.fifo_write, bus.in_ready}, 0);
        step();
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        @(negedge clk);
        chk("t4_abort", {bus.error, bus.busy, bus.row_valid}, 0);
        step();

        // 5: asynchronous reset mid-load, then a clean tile
        go(3);
        feed(5, -1, 0);
        bus.in_valid = 1'b1;
        #1 reset_n = 1'b0;
        #1 chk("t5_async_reset", {bus.busy, bus.in_ready, bus.fifo_write, bus.error}, 0);
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        step();
        for (int i = 0; i < 64; i++) src[i] = DW'(8'h30 + i);
        clr_logs();
        go(2);
        feed(8, -1, 0);
        wait_done("t5_done_seen", 30);
        chk("t5_nrd", rd_log.size(), 5);
        chk("t5_last_wd", wd_log.size() == 8 ? 32'(wd_log[7]) : 32'hdead, 8'h37);

        // 6: start during drain ignored, then back-to-back tiles
        for (int i = 0; i < 64; i++) src[i] = DW'(8'h50 + i);
        clr_logs();
        go(2);
        feed(8, -1, 0);
        step();
        bus.start = 1'b1;
        bus.k_len = 5'd5;
        step();
        bus.start = 1'b0;
        wait_done("t6_done_seen", 30);
        chk("t6_nrd", rd_log.size(), 5);
        for (int i = 0; i < 5; i++)
            chk($sformatf("t6_rd%0d", i), i < rd_log.size() ? 32'(rd_log[i]) : 32'hdead, exp_rd2[i]);
        clr_logs();
        go(1);
        feed(4, -1, 0);
        wait_done("t6_b2b_done_seen", 30);
        chk("t6_b2b_nrd", rd_log.size(), 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("t6_b2b_rd%0d", i), i < rd_log.size() ? 32'(rd_log[i]) : 32'hdead, exp_rd3[i]);

        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end
endmodule
